// File: rtl/regfile_pkg.sv
// Shared constants for the register file: default widths, register count
// and the index of the hard-wired zero register.
package regfile_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int NUM_REGS       = 32;
  localparam int ZERO_REG       = 0;

endpackage

// File: rtl/regfile_if.sv
// Register-file bus: one write port and two independent read ports.
// master = processor side (drives indices/write data), slave = register file.
interface regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  logic                  ctrl_writeEnable;
  logic [ADDR_WIDTH-1:0] ctrl_writeReg;
  logic [DATA_WIDTH-1:0] data_writeReg;
  logic [ADDR_WIDTH-1:0] ctrl_readRegA;
  logic [ADDR_WIDTH-1:0] ctrl_readRegB;
  logic [DATA_WIDTH-1:0] data_readRegA;
  logic [DATA_WIDTH-1:0] data_readRegB;

  modport master (
    output ctrl_writeEnable,
    output ctrl_writeReg,
    output data_writeReg,
    output ctrl_readRegA,
    output ctrl_readRegB,
    input  data_readRegA,
    input  data_readRegB
  );

  modport slave (
    input  ctrl_writeEnable,
    input  ctrl_writeReg,
    input  data_writeReg,
    input  ctrl_readRegA,
    input  ctrl_readRegB,
    output data_readRegA,
    output data_readRegB
  );

endinterface

// File: rtl/regfile_reg_cell.sv
// Single storage register with synchronous active-high clear and load enable.
module reg_cell #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  // Clear wins over load so a write coinciding with reset is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile.sv
// Register file: 2**ADDR_WIDTH registers, r0 hard-wired to zero, one write
// port and two combinational read ports.
// Optional build macro REGFILE_BYPASS_EN: forwards write data to a read port
// that addresses the register being written in the same cycle.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input logic       clock,
  input logic       reset,
  regfile_if.slave  bus
);

  localparam int N = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs [N];
  logic [N-1:1]          wr_sel;

  // One-hot write decode; r0 has no select line so writes to it vanish.
  always_comb begin
    wr_sel = '0;
    for (int i = 1; i < N; i++) begin
      wr_sel[i] = bus.ctrl_writeEnable && (bus.ctrl_writeReg == ADDR_WIDTH'(i));
    end
  end

  assign regs[0] = '0;

  for (genvar i = 1; i < N; i++) begin : g_cell
    reg_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
      .clock (clock),
      .reset (reset),
      .we    (wr_sel[i]),
      .d     (bus.data_writeReg),
      .q     (regs[i])
    );
  end

  // Shared read path, instantiated once per port so both ports are identical.
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] idx);
    logic [DATA_WIDTH-1:0] v;
    v = regs[idx];
`ifdef REGFILE_BYPASS_EN
    if (!reset && bus.ctrl_writeEnable && (bus.ctrl_writeReg != ZERO_IDX) &&
        (bus.ctrl_writeReg == idx)) begin
      v = bus.data_writeReg;
    end
`else
    if (ZERO_IDX == idx) begin
      v = '0;
    end
`endif
    return v;
  endfunction

  // Combinational read ports.
  always_comb begin
    bus.data_readRegA = read_port(bus.ctrl_readRegA);
    bus.data_readRegB = read_port(bus.ctrl_readRegB);
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus random traffic
// checked against an array model of the register contents.
module tb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;

  regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] model [NR];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_read(input int idx);
    if (idx == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (!reset && bus.ctrl_writeEnable && bus.ctrl_writeReg != 0 && int'(bus.ctrl_writeReg) == idx)
      return bus.data_writeReg;
`endif
    return model[idx];
  endfunction

  // One clock: drive at negedge, check reads mid-cycle, update model at the edge.
  task automatic step(input logic rst, input logic we, input int wa, input logic [DW-1:0] wd,
                      input int ra, input int rb, input string tag);
    @(negedge clock);
    reset                = rst;
    bus.ctrl_writeEnable = we;
    bus.ctrl_writeReg    = AW'(wa);
    bus.data_writeReg    = wd;
    bus.ctrl_readRegA    = AW'(ra);
    bus.ctrl_readRegB    = AW'(rb);
    #1;
    chk({tag, "_A"}, bus.data_readRegA, exp_read(ra));
    chk({tag, "_B"}, bus.data_readRegB, exp_read(rb));
    @(posedge clock);
    if (rst) begin
      for (int i = 0; i < NR; i++) model[i] = '0;
    end else if (we && wa != 0) begin
      model[wa] = wd;
    end
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < NR; i++) step(1'b0, 1'b0, 0, '0, i, i, tag);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) model[i] = 'x;
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_writeReg    = '0;
    bus.data_writeReg    = '0;
    bus.ctrl_readRegA    = '0;
    bus.ctrl_readRegB    = '0;
    reset                = 1'b1;
    @(posedge clock);
    for (int i = 0; i < NR; i++) model[i] = '0;

    // Reset clears everything.
    step(1'b1, 1'b0, 0, '0, 0, 0, "rst");
    read_all("post_rst");
    for (int i = 0; i < NR; i++) chk("post_rst_model", 32'(dut.regs[i]), 32'h0);

    // Basic write and neighbours.
    step(1'b0, 1'b1, 5, 32'hDEADBEEF, 0, 0, "wr5");
    step(1'b0, 1'b0, 0, '0, 5, 5, "rd5");
    chk("r5_const", bus.data_readRegA, 32'hDEADBEEF);
    step(1'b0, 1'b0, 0, '0, 4, 6, "rd4_6");
    chk("r6_zero", bus.data_readRegB, 32'h0);

    // Writes to r0 are discarded.
    step(1'b0, 1'b1, 0, 32'hFFFFFFFF, 0, 5, "wr0");
    read_all("after_wr0");

    // Enable low does nothing.
    step(1'b0, 1'b1, 7, 32'h11112222, 7, 7, "wr7a");
    step(1'b0, 1'b0, 7, 32'h12345678, 7, 0, "wr7_dis");
    step(1'b0, 1'b0, 0, '0, 7, 7, "rd7");
    chk("r7_const", bus.data_readRegA, 32'h11112222);

    // Same-cycle write/read of r9.
    step(1'b0, 1'b1, 9, 32'h0000ABCD, 9, 0, "wr9_same");
    step(1'b0, 1'b0, 0, '0, 9, 9, "rd9");
    chk("r9_const", bus.data_readRegB, 32'h0000ABCD);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, NR-1),
           $urandom, $urandom_range(0, NR-1), $urandom_range(0, NR-1), "rand");
    end

    // Fill with index, then reset concurrently with a write to r3.
    step(1'b1, 1'b0, 0, '0, 0, 0, "rst2");
    for (int i = 1; i < NR; i++) step(1'b0, 1'b1, i, DW'(i), i, NR-1-i, "fill");
    read_all("filled");
    step(1'b1, 1'b1, 3, 32'h55, 3, 4, "rst_wr3");
    read_all("after_rst2");
    step(1'b0, 1'b0, 0, '0, 3, 3, "rd3");
    chk("r3_const", bus.data_readRegA, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
